// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer.
//   mode_e    : animation mode encodings (OFF, BLINK, CHASE, BOUNCE)
//   SPEED_MAX : highest speed index, after which speed wraps to 0
//   NUM_LEDS  : number of LEDs driven by the sequencer
//   next_speed: speed index advance with wrap
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam int SPEED_MAX = 2;
  localparam int NUM_LEDS  = 6;

  function automatic logic [1:0] next_speed(input logic [1:0] s);
    return (s == 2'(SPEED_MAX)) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioning for one active-low pushbutton.
// A 2-FF synchroniser feeds a debouncer; a new level is accepted after it
// has been seen continuously for DEBOUNCE_CYCLES cycles. A registered
// one-cycle pulse marks the accepted press (stable level 1 -> 0).
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   btn_n : raw button pin, active-low, asynchronous to clk
//   press : one-cycle press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d  = btn_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    // The counter only runs while the synced level disagrees with the
    // accepted level, so any bounce back restarts the qualification.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer for the Tang Nano 9K: S1 cycles the animation mode
// (OFF, BLINK, CHASE, BOUNCE), S2 cycles the speed (step period
// STEP_CYCLES >> speed). LED outputs are registered and active-low.
// Optional build macro: LED_PWM_DIM_EN -- dims lit LEDs with a free-running
// 8-bit PWM counter, lit only while the counter is below DIM_DUTY.
// Ports:
//   clk   : 27 MHz clock
//   rst   : synchronous active-high reset
//   s1_n  : mode button, active-low, asynchronous
//   s2_n  : speed button, active-low, asynchronous
//   led_n : LED drives, active-low, bit 0 = first LED
//   mode  : current mode
//   speed : current speed index 0..2
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int STEP_CYCLES     = 6750000,
  parameter int DIM_DUTY        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s1_n,
  input  logic                s2_n,
  output logic [NUM_LEDS-1:0] led_n,
  output logic [1:0]          mode,
  output logic [1:0]          speed
);

  localparam int PRESC_W = $clog2(STEP_CYCLES);
  typedef logic [PRESC_W-1:0] presc_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (STEP_CYCLES < 4 || (STEP_CYCLES % 4) != 0) begin : g_chk_step
    $error("STEP_CYCLES must be >= 4 and a multiple of 4");
  end
  if (DIM_DUTY < 0 || DIM_DUTY > 255) begin : g_chk_dim
    $error("DIM_DUTY must be in 0..255");
  end

  logic s1_press, s2_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_s1 (
    .clk   (clk),
    .rst   (rst),
    .btn_n (s1_n),
    .press (s1_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_s2 (
    .clk   (clk),
    .rst   (rst),
    .btn_n (s2_n),
    .press (s2_press)
  );

  mode_e               mode_q, mode_d;
  logic [1:0]          speed_q, speed_d;
  logic [NUM_LEDS-1:0] pattern_q, pattern_d;
  logic                dir_up_q, dir_up_d;
  logic                phase_q, phase_d;
  presc_t              presc_q, presc_d;
  logic [NUM_LEDS-1:0] led_n_q, led_n_d;
  logic [NUM_LEDS-1:0] lit;
  presc_t              term;
  logic                tick;
`ifdef LED_PWM_DIM_EN
  logic [7:0]          pwm_q, pwm_d;
`endif

  // Terminal count shrinks by a power of two per speed step.
  always_comb begin
    case (speed_q)
      2'd1:    term = presc_t'((STEP_CYCLES >> 1) - 1);
      2'd2:    term = presc_t'((STEP_CYCLES >> 2) - 1);
      default: term = presc_t'(STEP_CYCLES - 1);
    endcase
  end

  assign tick = (presc_q == term);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_OFF;
      speed_q   <= 2'd0;
      pattern_q <= NUM_LEDS'(1);
      dir_up_q  <= 1'b1;
      phase_q   <= 1'b1;
      presc_q   <= '0;
      led_n_q   <= '1;
`ifdef LED_PWM_DIM_EN
      pwm_q     <= '0;
`endif
    end else begin
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      pattern_q <= pattern_d;
      dir_up_q  <= dir_up_d;
      phase_q   <= phase_d;
      presc_q   <= presc_d;
      led_n_q   <= led_n_d;
`ifdef LED_PWM_DIM_EN
      pwm_q     <= pwm_d;
`endif
    end
  end

  // A press cycle restarts the step period and takes priority over a
  // coinciding tick, so the pattern never advances on a press cycle.
  always_comb begin
    mode_d    = mode_q;
    speed_d   = speed_q;
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    phase_d   = phase_q;
    presc_d   = presc_q + presc_t'(1);
    if (s1_press || s2_press) begin
      presc_d = '0;
      if (s1_press) begin
        mode_d    = mode_e'(mode_q + 2'd1);
        pattern_d = NUM_LEDS'(1);
        dir_up_d  = 1'b1;
        phase_d   = 1'b1;
      end
      if (s2_press) begin
        speed_d = next_speed(speed_q);
      end
    end else if (tick) begin
      presc_d = '0;
      case (mode_q)
        MODE_BLINK:  phase_d = ~phase_q;
        MODE_CHASE:  pattern_d = {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
        MODE_BOUNCE: begin
          // Turning at an end moves away immediately, so end positions
          // are shown for a single step.
          if (dir_up_q) begin
            if (pattern_q[NUM_LEDS-1]) begin
              dir_up_d  = 1'b0;
              pattern_d = pattern_q >> 1;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              dir_up_d  = 1'b1;
              pattern_d = pattern_q << 1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (mode_q)
      MODE_BLINK:               lit = {NUM_LEDS{phase_q}};
      MODE_CHASE, MODE_BOUNCE:  lit = pattern_q;
      default:                  lit = '0;
    endcase
`ifdef LED_PWM_DIM_EN
    pwm_d = pwm_q + 8'd1;
    if (pwm_q >= 8'(DIM_DUTY)) begin
      lit = '0;
    end
`endif
    led_n_d = ~lit;
  end

  assign led_n = led_n_q;
  assign mode  = mode_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  localparam int DB   = 4;
  localparam int STEP = 16;
  localparam int DIM  = 64;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       s1_n;
  logic       s2_n;
  logic [5:0] led_n;
  logic [1:0] mode;
  logic [1:0] speed;

  always #5 clk = ~clk;

  led_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .STEP_CYCLES     (STEP),
    .DIM_DUTY        (DIM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s1_n  (s1_n),
    .s2_n  (s2_n),
    .led_n (led_n),
    .mode  (mode),
    .speed (speed)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // pinX[c]: pin level driven after edge c; pendX[c]: press takes effect at edge c
  bit pin1 [MAXC];
  bit pin2 [MAXC];
  bit pend1[MAXC];
  bit pend2[MAXC];

  // Reference model: mode, speed, cycles into current step, steps since mode entry
  int         m_mode, m_speed, m_cnt, m_idx, m_pwm;
  logic [5:0] m_led;

  function automatic logic [5:0] lit_of(int md, int idx);
    int k;
    case (md)
      1: return (idx % 2 == 0) ? 6'h3f : 6'h00;
      2: return 6'(1 << (idx % 6));
      3: begin
        k = idx % 10;
        return 6'(1 << ((k <= 5) ? k : 10 - k));
      end
      default: return 6'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_speed = 0;
    m_cnt   = 0;
    m_idx   = 0;
    m_pwm   = 0;
    m_led   = 6'h3f;
  endtask

  task automatic model_edge(input bit p1, input bit p2);
    logic [5:0] lit;
    lit = lit_of(m_mode, m_idx);
`ifdef LED_PWM_DIM_EN
    if (m_pwm >= DIM) lit = 6'h00;
    m_pwm = (m_pwm + 1) % 256;
`endif
    m_led = ~lit;
    if (p1 || p2) begin
      if (p1) begin
        m_mode = (m_mode + 1) % 4;
        m_idx  = 0;
      end
      if (p2) m_speed = (m_speed + 1) % 3;
      m_cnt = 0;
    end else if (m_cnt == (STEP >> m_speed) - 1) begin
      m_cnt = 0;
      m_idx++;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (led_n === m_led) else begin
      errors++;
      $error("FAIL led_n cyc=%0d observed=%b expected=%b", cyc, led_n, m_led);
    end
    checks++;
    assert (mode === 2'(m_mode)) else begin
      errors++;
      $error("FAIL mode cyc=%0d observed=%0d expected=%0d", cyc, mode, m_mode);
    end
    checks++;
    assert (speed === 2'(m_speed)) else begin
      errors++;
      $error("FAIL speed cyc=%0d observed=%0d expected=%0d", cyc, speed, m_speed);
    end
  endtask

  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC - 1) begin
      $error("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    if (r) model_reset();
    else   model_edge(pend1[cyc], pend2[cyc]);
    check_outputs();
    s1_n = pin1[cyc];
    s2_n = pin2[cyc];
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  // Low pulse of L cycles starting after edge n; accepted only if L >= DB,
  // taking effect 2 sync + DB debounce + 1 pulse register edges later.
  task automatic press_at(input int btn, input int n, input int len);
    for (int k = 0; k < len; k++) begin
      if (btn == 1) pin1[n + k] = 1'b0;
      else          pin2[n + k] = 1'b0;
    end
    if (len >= DB) begin
      if (btn == 1) pend1[n + 2 + DB + 1] = 1'b1;
      else          pend2[n + 2 + DB + 1] = 1'b1;
    end
  endtask

  initial begin
    bit found;
    int n;
    int mask;
    for (int i = 0; i < MAXC; i++) begin
      pin1[i] = 1'b1;
      pin2[i] = 1'b1;
    end
    rst  = 1'b1;
    s1_n = 1'b1;
    s2_n = 1'b1;
    model_reset();

    // reset held, then idle stability
    run(3);
    rst = 1'b0;
    run(100);

    // short glitch rejected, then a real press into BLINK
    press_at(1, cyc + 1, 3);
    run(20);
    press_at(1, cyc + 1, 10);
    run(60);

    // CHASE with full wrap at speed 0
    press_at(1, cyc + 1, 6);
    run(16 * 7 + 20);

    // BOUNCE, then speed 1
    press_at(1, cyc + 1, 6);
    run(20);
    press_at(2, cyc + 1, 6);
    run(8 * 13 + 10);

    // speed 2 then wrap to 0
    press_at(2, cyc + 1, 5);
    run(20);
    press_at(2, cyc + 1, 5);
    run(20);

    // simultaneous presses
    n = cyc + 1;
    press_at(1, n, 6);
    press_at(2, n, 6);
    run(40);

    // random presses and glitches on either or both buttons
    for (int it = 0; it < 40; it++) begin
      int l1, l2;
      n    = cyc + 1;
      mask = $urandom_range(1, 3);
      l1   = $urandom_range(1, 8);
      l2   = $urandom_range(1, 8);
      if (mask[0]) press_at(1, n, l1);
      if (mask[1]) press_at(2, n, l2);
      run(((l1 > l2) ? l1 : l2) + $urandom_range(6, 20));
    end

    // reach BOUNCE, wait for pattern 8, then reset mid-animation
    for (int t = 0; t < 4 && m_mode != 3; t++) begin
      press_at(1, cyc + 1, 5);
      run(12);
    end
    found = (m_mode == 3) && (lit_of(m_mode, m_idx) == 6'd8);
    for (int t = 0; t < 400 && !found; t++) begin
      step();
      found = (m_mode == 3) && (lit_of(m_mode, m_idx) == 6'd8);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL bounce_reach observed=mode%0d expected=mode3_pattern8", m_mode);
    end
    rst = 1'b1;
    step();
    checks++;
    assert (mode === 2'd0 && led_n === 6'h3f) else begin
      errors++;
      $error("FAIL mid_reset observed=%0d/%b expected=0/111111", mode, led_n);
    end
    rst = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
